// File: rtl/alu4_seq_ctrl_if.sv
// Board-side bundle for the ALU push-button sequencer: raw buttons, switches,
// ALU operand/result buses, captured result/flags and status.
interface alu4_seq_ctrl_if;
    logic       push1;
    logic       push2;
    logic       push3;
    logic [3:0] no;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] opcode;
    logic       alu_go;
    logic [3:0] alu_res;
    logic       alu_cout;
    logic [3:0] res;
    logic       cf;
    logic       zf;
    logic       sf;
    logic       valid;
    logic       seq_err;
    logic [2:0] state;

    modport master (
        output push1, push2, push3, no, alu_res, alu_cout,
        input  op_a, op_b, opcode, alu_go, res, cf, zf, sf, valid, seq_err, state
    );

    modport slave (
        input  push1, push2, push3, no, alu_res, alu_cout,
        output op_a, op_b, opcode, alu_go, res, cf, zf, sf, valid, seq_err, state
    );
endinterface

// File: rtl/alu4_seq_ctrl.sv
// Push-button sequencer for alu4: debounces three buttons, loads A/B/opcode, strobes the ALU
// and captures result plus cf/zf/sf. Define ALU_SEQ_ACCUM_EN for accumulator (chained) mode.
module alu4_seq_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned DEB_W      = 20
) (
    input logic            clk,
    input logic            reset,
    alu4_seq_ctrl_if.slave bus
);

    localparam logic [DEB_W-1:0] CntMax = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] CntArm = DEB_W'(DEB_CYCLES - 2);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StGotA = 3'd1,
        StGotB = 3'd2,
        StExec = 3'd3,
        StCapt = 3'd4,
        StDone = 3'd5
    } state_e;

    // Button conditioning
    logic [2:0]       raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       press_q;
    logic [DEB_W-1:0] cnt_q [3];

    assign raw = {bus.push3, bus.push2, bus.push1};

    // Counter saturates at CntMax so a held button yields exactly one pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (!sync2_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != CntMax) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
                press_q[i] <= sync2_q[i] && (cnt_q[i] == CntArm);
            end
        end
    end

    // Sequencer
    state_e     state_q, state_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic [3:0] opcode_q, opcode_d;
    logic [3:0] res_q, res_d;
    logic       cf_q, cf_d;
    logic       zf_q, zf_d;
    logic       sf_q, sf_d;
    logic       valid_q, valid_d;
    logic       seq_err_q, seq_err_d;
    logic       p1, p2, p3;
    logic       l1, l2, l3;

    assign p1 = press_q[0];
    assign p2 = press_q[1];
    assign p3 = press_q[2];

    // Legal presses per state; priority among them is p3 > p2 > p1.
    assign l1 = p1 && (state_q inside {StIdle, StGotA, StGotB, StDone});
`ifdef ALU_SEQ_ACCUM_EN
    assign l2 = p2 && (state_q inside {StGotA, StDone});
`else
    assign l2 = p2 && (state_q == StGotA);
`endif
    assign l3 = p3 && (state_q == StGotB);

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        opcode_d  = opcode_q;
        res_d     = res_q;
        cf_d      = cf_q;
        zf_d      = zf_q;
        sf_d      = sf_q;
        valid_d   = valid_q;
        seq_err_d = (p1 || p2 || p3) && !(l1 || l2 || l3);

        case (state_q)
            StIdle, StGotA, StGotB, StDone: begin
                if (l3) begin
                    opcode_d = bus.no;
                    state_d  = StExec;
                end else if (l2) begin
                    op_b_d  = bus.no;
                    state_d = StGotB;
                end else if (l1) begin
                    op_a_d  = bus.no;
                    valid_d = 1'b0;
                    state_d = StGotA;
                end
            end
            StExec: begin
                state_d = StCapt;
            end
            StCapt: begin
                res_d   = bus.alu_res;
                cf_d    = bus.alu_cout;
                zf_d    = (bus.alu_res == 4'd0);
                sf_d    = bus.alu_res[3];
                valid_d = 1'b1;
`ifdef ALU_SEQ_ACCUM_EN
                op_a_d  = bus.alu_res;
`endif
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_a_q    <= '0;
            op_b_q    <= '0;
            opcode_q  <= '0;
            res_q     <= '0;
            cf_q      <= 1'b0;
            zf_q      <= 1'b0;
            sf_q      <= 1'b0;
            valid_q   <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            opcode_q  <= opcode_d;
            res_q     <= res_d;
            cf_q      <= cf_d;
            zf_q      <= zf_d;
            sf_q      <= sf_d;
            valid_q   <= valid_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.op_a    = op_a_q;
    assign bus.op_b    = op_b_q;
    assign bus.opcode  = opcode_q;
    assign bus.alu_go  = (state_q == StExec);
    assign bus.res     = res_q;
    assign bus.cf      = cf_q;
    assign bus.zf      = zf_q;
    assign bus.sf      = sf_q;
    assign bus.valid   = valid_q;
    assign bus.seq_err = seq_err_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Bench for alu4_seq_ctrl: directed scenarios plus random press sequences checked against a
// transaction-level model of the sequencer and a behavioural ALU.
module tb_alu4_seq_ctrl;

    localparam int DEB = 4;
`ifdef ALU_SEQ_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    alu4_seq_ctrl_if bus ();

    alu4_seq_ctrl #(
        .DEB_CYCLES(DEB),
        .DEB_W     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0 add, 1 and, 2 xor, others or.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a & b};
            4'd2:    return {1'b0, a ^ b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    logic [4:0] alu_r;
    assign alu_r        = alu_f(bus.op_a, bus.op_b, bus.opcode);
    assign bus.alu_res  = alu_r[3:0];
    assign bus.alu_cout = alu_r[4];

    logic [24:0] outs;
    assign outs = {bus.op_a, bus.op_b, bus.opcode, bus.res, bus.cf, bus.zf, bus.sf, bus.valid,
                   bus.alu_go, bus.seq_err, bus.state};

    int err_cnt = 0;
    int go_cnt  = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.seq_err) err_cnt++;
            if (bus.alu_go) go_cnt++;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_st;
    logic [3:0] m_a, m_b, m_op, m_res;
    logic       m_cf, m_zf, m_sf, m_valid;
    int         exp_err = 0;
    int         exp_go  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0;
        m_cf = 0; m_zf = 0; m_sf = 0; m_valid = 0;
    endtask

    task automatic model_press(input logic [2:0] mask, input logic [3:0] val);
        bit l1, l2, l3;
        logic [4:0] r;
        l1 = mask[0] && (m_st == 0 || m_st == 1 || m_st == 2 || m_st == 5);
        l2 = mask[1] && (m_st == 1 || (ACCUM && m_st == 5));
        l3 = mask[2] && (m_st == 2);
        if (l3) begin
            m_op    = val;
            r       = alu_f(m_a, m_b, val);
            m_res   = r[3:0];
            m_cf    = r[4];
            m_zf    = (r[3:0] == 4'd0);
            m_sf    = r[3];
            m_valid = 1'b1;
            if (ACCUM) m_a = r[3:0];
            m_st    = 5;
            exp_go++;
        end else if (l2) begin
            m_b  = val;
            m_st = 2;
        end else if (l1) begin
            m_a     = val;
            m_valid = 1'b0;
            m_st    = 1;
        end else if (mask != 3'b000) begin
            exp_err++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"}, 32'(bus.state), 32'(m_st));
        chk({tag, ".op_a"}, 32'(bus.op_a), 32'(m_a));
        chk({tag, ".op_b"}, 32'(bus.op_b), 32'(m_b));
        chk({tag, ".opcode"}, 32'(bus.opcode), 32'(m_op));
        chk({tag, ".res"}, 32'(bus.res), 32'(m_res));
        chk({tag, ".flags"}, 32'({bus.cf, bus.zf, bus.sf, bus.valid}),
            32'({m_cf, m_zf, m_sf, m_valid}));
        chk({tag, ".seq_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, ".alu_go_cnt"}, 32'(go_cnt), 32'(exp_go));
    endtask

    task automatic press(input logic [2:0] mask, input logic [3:0] val);
        bus.no = val;
        {bus.push3, bus.push2, bus.push1} = mask;
        repeat (DEB + 4) @(negedge clk);
        {bus.push3, bus.push2, bus.push1} = 3'b000;
        repeat (8) @(negedge clk);
        model_press(mask, val);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Press p3 and check the strobe/capture cycle by cycle.
    task automatic exec_timed(input string tag, input logic [3:0] val);
        int n;
        bus.no    = val;
        bus.push3 = 1'b1;
        n = 0;
        while (!bus.alu_go && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".go_seen"}, 32'(bus.alu_go), 32'd1);
        chk({tag, ".valid_exec"}, 32'(bus.valid), 32'd0);
        @(negedge clk);
        chk({tag, ".go_one_cycle"}, 32'(bus.alu_go), 32'd0);
        chk({tag, ".valid_capt"}, 32'(bus.valid), 32'd0);
        @(negedge clk);
        chk({tag, ".valid_done"}, 32'(bus.valid), 32'd1);
        chk({tag, ".state_done"}, 32'(bus.state), 32'd5);
        repeat (4) @(negedge clk);
        bus.push3 = 1'b0;
        repeat (8) @(negedge clk);
        model_press(3'b100, val);
    endtask

    initial begin
        logic [2:0] mask;
        logic [3:0] val;
        bit         changed;
        int         n;

        bus.push1 = 1'b0;
        bus.push2 = 1'b0;
        bus.push3 = 1'b0;
        bus.no    = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("reset_idle", 32'(outs), 32'd0);
        end

        // 0001 + 1100 -> 1101
        press(3'b001, 4'b0001);
        press(3'b010, 4'b1100);
        exec_timed("add1", 4'b0000);
        chk("add1.res", 32'(bus.res), 32'hD);
        chk("add1.cf_zf_sf", 32'({bus.cf, bus.zf, bus.sf}), 32'b001);
        check_model("add1");

        // 1000 + 1000 -> 0000 with carry
        press(3'b001, 4'b1000);
        press(3'b010, 4'b1000);
        exec_timed("add2", 4'b0000);
        chk("add2.res", 32'(bus.res), 32'h0);
        chk("add2.cf_zf_sf", 32'({bus.cf, bus.zf, bus.sf}), 32'b110);
        check_model("add2");

        // Bouncing push1 then a long hold: exactly one press accepted
        do_reset();
        bus.no = 4'hA;
        for (int i = 0; i < 5; i++) begin
            bus.push1 = 1'b1;
            repeat (2) @(negedge clk);
            bus.push1 = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("bounce.quiet_state", 32'(bus.state), 32'd0);
        bus.push1 = 1'b1;
        changed   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!changed && bus.state == 3'd1) begin
                bus.no  = 4'h5;
                changed = 1'b1;
            end
        end
        bus.push1 = 1'b0;
        repeat (8) @(negedge clk);
        chk("bounce.accepted", 32'(changed), 32'd1);
        model_press(3'b001, 4'hA);
        check_model("bounce");

        // Out-of-order p3 in IDLE, then p1+p2 together
        do_reset();
        press(3'b100, 4'h7);
        check_model("p3_idle");
        press(3'b011, 4'h6);
        check_model("p1p2_idle");

        // Reset while in EXEC
        press(3'b010, 4'h3);
        bus.no    = 4'h2;
        bus.push3 = 1'b1;
        n = 0;
        while (!bus.alu_go && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rst_exec.go_seen", 32'(bus.alu_go), 32'd1);
        reset     = 1'b1;
        bus.push3 = 1'b0;
        @(negedge clk);
        chk("rst_exec.outputs", 32'(outs), 32'd0);
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        exp_go = go_cnt;
        chk("rst_exec.after", 32'(outs), 32'd0);

`ifdef ALU_SEQ_ACCUM_EN
        press(3'b001, 4'b0001);
        press(3'b010, 4'b1100);
        press(3'b100, 4'b0000);
        chk("accum.op_a", 32'(bus.op_a), 32'hD);
        press(3'b010, 4'b0011);
        press(3'b100, 4'b0000);
        chk("accum.res", 32'(bus.res), 32'h0);
        chk("accum.cf_zf", 32'({bus.cf, bus.zf}), 32'b11);
        check_model("accum");
`endif

        // Random press sequences
        for (int i = 0; i < 40; i++) begin
            n   = int'($urandom_range(0, 9));
            val = 4'($urandom);
            if (n < 6) begin
                case (m_st)
                    1:       mask = 3'b010;
                    2:       mask = 3'b100;
                    default: mask = 3'b001;
                endcase
            end else if (n < 9) begin
                mask = 3'b001 << $urandom_range(0, 2);
            end else begin
                mask = 3'($urandom_range(1, 7));
            end
            press(mask, val);
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
